lcd_cmd_arbiter: RTL
====================

# lcd_cmd_arbiter

Command scheduler in front of the LCD image controller. Two independent hosts (A, B) submit 4-bit image commands. A round-robin arbiter merges them into one in-order command FIFO. An issue FSM feeds the FIFO to the LCD controller using its `cmd`/`cmd_valid`/`busy`/`done` handshake. When a write command (0x0) is issued, the block stops accepting commands and waits for the controller's `done`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high.
- `a_cmd`  in  4  host A command code (0x0 write, 0x1–0x4 shift, 0x5–0xB op).
- `a_valid`  in  1  host A request.
- `a_ready`  out  1  host A accepted this cycle when `a_valid && a_ready`.
- `b_cmd`, `b_valid`, `b_ready`: same as host A, for host B.
- `cmd`  out  4  command to the LCD controller (registered).
- `cmd_valid`  out  1  one-cycle issue pulse (registered).
- `busy`  in  1  LCD controller busy; resets high in the controller.
- `done`  in  1  LCD controller finished writing IRAM.
- `fin`  out  1  sticky; high once `done` is seen after a write is issued.
- `fifo_count`  out  clog2(DEPTH)+1  number of occupied FIFO entries.

## Operation
- **Accept.**
  - `can_push = !reset && !closed && count < DEPTH`.
  - Only one push per cycle. Pop in the same cycle does not free a slot for that cycle's push.
- **Arbitration.**
  - Only one host valid: that host gets ready = `can_push`.
  - Both hosts valid: the host not named by `last_grant` wins, and the loser's ready is 0.
  - `last_grant` updates only on an actual push. It resets to B, so A wins the first tie.
- **Close.** Pushing code 0x0 sets `closed`. After that both readies stay 0 until reset. Entries queued before the 0x0 still issue.
- **Issue FSM states:** IDLE, WAIT_HI, WAIT_LO, WAIT_DONE, FIN.
  - IDLE: when `count>0 && !busy`, register `cmd<=head`, `cmd_valid<=1`, and pop. Go to WAIT_DONE if head==0x0, else WAIT_HI.
  - WAIT_HI: `cmd_valid<=0`. Go to WAIT_LO when `busy==1`.
  - WAIT_LO: go to IDLE when `busy==0`.
  - WAIT_DONE: `cmd_valid<=0`. Go to FIN when `done==1`. The FIFO is flushed (count←0) on entry, because nothing after a write is legal.
  - FIN: `fin<=1`. Terminal state until reset.
- Codes 0xC–0xF are forwarded unchanged; the controller treats them as no-ops.
- **FIFO:** circular buffer with DEPTH-wrapping read and write pointers. Full = count==DEPTH, empty = count==0.

## Timing
- **Reset values:** `cmd=0`, `cmd_valid=0`, `fin=0`, `fifo_count=0`, state IDLE, `closed=0`, `last_grant=B`, pointers 0. Both readies are 0 while `reset` is high.
- **Push latency:** a command accepted on edge k is visible at the head on edge k, so it can be issued on edge k+1 at the earliest (`cmd_valid` high after edge k+1).
- **Handshake:**
  - `cmd_valid` is high for exactly one cycle, and only when `busy` was sampled 0.
  - The controller samples it while `busy==0`, then raises `busy` one edge later.
  - Minimum spacing between two issues is 4 cycles: IDLE, WAIT_HI, WAIT_LO, IDLE.
- **Startup:** while the controller loads IROM, `busy` is 1, so the FIFO fills and holds. Hosts see ready drop at full.
- **Simultaneous events:**
  - Push and pop in the same cycle: count unchanged. This requires count<DEPTH before the edge.
  - A push of 0x0 in the same cycle as a pop: both occur.
- **Reset mid-operation:** all state returns to reset values immediately. Queued commands are lost, and `cmd_valid` drops asynchronously.

## Configuration
- `LCD_ARB_FIXED_PRIO_EN` defined: host A always wins ties and `last_grant` is unused.
- Undefined (default): round-robin as specified above.

## Structure
- Shared package `lcd_pkg`:
  - command code constants `CMD_WRITE=4'h0` through `CMD_MIRROR_X=4'hB`
  - issue-state enum (IDLE…FIN)
  - host-ID constants A/B
- One sub-module, `lcd_cmd_fifo` (parameter DEPTH, 4-bit data; push/pop/count/head/flush). Arbiter and FSM stay in the top.

## Test plan
1. Reset, then `busy` held 1 for 70 cycles. A pushes 0x1, 0x2, 0x3, 0x4, then a 5th push is attempted. Required: `a_ready` low on the 5th push, `fifo_count=4`. When `busy` falls, commands issue as 0x1, 0x2, 0x3, 0x4, each as a 1-cycle `cmd_valid` spaced ≥4 cycles apart.
2. A and B both valid every cycle with A=0x5 and B=0x6, controller idle. Required: pushes alternate A, B, A, B, …, and the issued `cmd` sequence is 0x5, 0x6, 0x5, 0x6.
   - With `LCD_ARB_FIXED_PRIO_EN`: every issued command is 0x5.
3. Queue 0x7, then 0x0, then attempt B 0x8. Required:
   - `b_ready=0` after the 0x0 push.
   - Issue order 0x7 then 0x0; 0x8 is never issued.
   - `fin=1` one edge after `done` rises.
4. Bench keeps `busy=1` for 10 cycles after the issue. Required: no second `cmd_valid` until `busy` returns to 0.
5. Assert `reset` while in WAIT_LO with 3 entries queued. Required: `cmd_valid=0`, `fifo_count=0`, `fin=0` immediately. After release, A wins the first tie.
6. Push and pop in the same cycle at count=2. Required: count stays 2, and FIFO order is preserved across pointer wrap (≥DEPTH+2 commands).

Source files
------------

// File: rtl/lcd_pkg.sv
// ============================================================================
// Module      : lcd_pkg
// Description : Shared command codes, host IDs and issue-FSM states for the
//               LCD command scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam logic [3:0] CMD_WRITE       = 4'h0;
    localparam logic [3:0] CMD_SHIFT_UP    = 4'h1;
    localparam logic [3:0] CMD_SHIFT_DOWN  = 4'h2;
    localparam logic [3:0] CMD_SHIFT_LEFT  = 4'h3;
    localparam logic [3:0] CMD_SHIFT_RIGHT = 4'h4;
    localparam logic [3:0] CMD_MAX         = 4'h5;
    localparam logic [3:0] CMD_MIN         = 4'h6;
    localparam logic [3:0] CMD_AVERAGE     = 4'h7;
    localparam logic [3:0] CMD_ROT_CCW     = 4'h8;
    localparam logic [3:0] CMD_ROT_CW      = 4'h9;
    localparam logic [3:0] CMD_MIRROR_Y    = 4'hA;
    localparam logic [3:0] CMD_MIRROR_X    = 4'hB;

    localparam logic HOST_A = 1'b0;
    localparam logic HOST_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HI   = 3'd1,
        ST_WAIT_LO   = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FIN       = 3'd4
    } issue_state_t;

endpackage

`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
// ============================================================================
// Module      : lcd_cmd_fifo
// Description : DEPTH-entry circular command FIFO with head view and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [3:0]               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [3:0]               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !pop)
                r_count <= r_count + 1'b1;
            else if (pop && !push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/lcd_cmd_arbiter.sv
// ============================================================================
// Module      : lcd_cmd_arbiter
// Description : Two-host round-robin command merge, FIFO and issue FSM for the
//               LCD controller. Define LCD_ARB_FIXED_PRIO_EN for A-first ties.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_cmd_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               a_cmd,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [3:0]               b_cmd,
    input  logic                     b_valid,
    output logic                     b_ready,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    input  logic                     busy,
    input  logic                     done,
    output logic                     fin,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    import lcd_pkg::*;

    localparam int              CW     = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   c_full = CW'(DEPTH);

    logic          w_can_push;
    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_push;
    logic [3:0]    w_push_data;
    logic          w_pop;
    logic          w_flush;
    logic [3:0]    w_head;
    logic [CW-1:0] w_count;
    logic          r_closed;

    issue_state_t  r_state;
    issue_state_t  w_state_next;
    logic [3:0]    r_cmd;
    logic [3:0]    w_cmd_next;
    logic          r_cmd_valid;
    logic          w_cmd_valid_next;
    logic          r_fin;
    logic          w_fin_next;

    // A slot freed by a same-cycle pop is not reusable until the next cycle.
    assign w_can_push = !reset && !r_closed && (w_count != c_full);

`ifdef LCD_ARB_FIXED_PRIO_EN
    assign w_grant_a = a_valid;
`else
    logic r_last_grant;

    assign w_grant_a = a_valid && (!b_valid || (r_last_grant == HOST_B));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last_grant <= HOST_B;
        else if (w_push)
            r_last_grant <= w_grant_a ? HOST_A : HOST_B;
    end
`endif

    assign w_grant_b   = b_valid && !w_grant_a;
    assign a_ready     = w_can_push && w_grant_a;
    assign b_ready     = w_can_push && w_grant_b;
    assign w_push      = a_ready || b_ready;
    assign w_push_data = w_grant_a ? a_cmd : b_cmd;

    // Once a write is queued nothing further may enter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_closed <= 1'b0;
        else if (w_push && (w_push_data == CMD_WRITE))
            r_closed <= 1'b1;
    end

    lcd_cmd_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (w_flush),
        .head      (w_head),
        .count     (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd       <= 4'h0;
            r_cmd_valid <= 1'b0;
            r_fin       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cmd       <= w_cmd_next;
            r_cmd_valid <= w_cmd_valid_next;
            r_fin       <= w_fin_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cmd_next       = r_cmd;
        w_cmd_valid_next = 1'b0;
        w_fin_next       = r_fin;
        w_pop            = 1'b0;
        w_flush          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((w_count != '0) && !busy) begin
                    w_cmd_next       = w_head;
                    w_cmd_valid_next = 1'b1;
                    w_pop            = 1'b1;
                    if (w_head == CMD_WRITE) begin
                        // Anything queued behind a write can never be legal.
                        w_flush      = 1'b1;
                        w_state_next = ST_WAIT_DONE;
                    end else begin
                        w_state_next = ST_WAIT_HI;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (busy) w_state_next = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!busy) w_state_next = ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    w_state_next = ST_FIN;
                    w_fin_next   = 1'b1;
                end
            end
            ST_FIN: begin
                w_fin_next = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign cmd        = r_cmd;
    assign cmd_valid  = r_cmd_valid;
    assign fin        = r_fin;
    assign fifo_count = w_count;

endmodule

`default_nettype wire
